// File: rtl/ram_arbiter_2p_if.sv
// ----------------------------------------------------------------------------
// ram_arbiter_2p_if
//
// Bundles every signal between the CPU ports, the arbiter and the single-port
// RAM so the arbiter can take them as one port.
//
// Signal groups:
//   instruction port : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   data port        : d_req, d_we, d_addr, d_wdata, d_lock
//                      -> d_gnt, d_rvalid, d_rdata
//   RAM side         : mem_address, mem_write, mem_read, mem_writedata
//                      <- mem_readdata
//   performance      : i_grant_cnt, d_grant_cnt, i_stall_cnt, d_stall_cnt
//
// Modports:
//   master : the environment (CPU core plus RAM instance)
//   slave  : the arbiter
//
// Handshake: a requester raises req with its address/data and holds all of
// them stable until it sees gnt=1 in the same cycle; the transfer completes
// at that rising edge. A granted read returns rvalid/rdata exactly one cycle
// later, with no back-pressure on the response.
// ----------------------------------------------------------------------------
interface ram_arbiter_2p_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // instruction port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    // data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_lock;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // RAM side
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    // performance counters
    logic [CNT_W-1:0]  i_grant_cnt;
    logic [CNT_W-1:0]  d_grant_cnt;
    logic [CNT_W-1:0]  i_stall_cnt;
    logic [CNT_W-1:0]  d_stall_cnt;

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        output mem_readdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_address, mem_write, mem_read, mem_writedata,
        input  i_grant_cnt, d_grant_cnt, i_stall_cnt, d_stall_cnt
    );

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        input  mem_readdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_address, mem_write, mem_read, mem_writedata,
        output i_grant_cnt, d_grant_cnt, i_stall_cnt, d_stall_cnt
    );
endinterface

// File: rtl/ram_arbiter_2p.sv
// ----------------------------------------------------------------------------
// ram_arbiter_2p
//
// Shares one single-port synchronous RAM between the CPU instruction-fetch
// port and data port. At most one access is granted per cycle:
//   1. an active data-port lock with d_req=1 wins,
//   2. otherwise a lone requester wins,
//   3. otherwise the port not granted most recently wins (round-robin).
// A lock (read-modify-write) is bounded: after MAX_LOCK consecutive locked
// data grants while the instruction port waits, the lock is ignored for one
// arbitration so the instruction port gets through.
// Read data, registered inside the RAM, is routed back one cycle later to the
// port that issued the read. Saturating grant/stall counters per port.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset_n  : asynchronous active-low reset; grants, strobes and rvalids
//              are held low while it is asserted
//   bus      : ram_arbiter_2p_if.slave (CPU ports, RAM side, counters)
// ----------------------------------------------------------------------------
module ram_arbiter_2p #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    ram_arbiter_2p_if.slave    bus
);

    localparam logic [3:0] MAX_LOCK_L = 4'(MAX_LOCK);

    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lock_state_e       lock_state_q, lock_state_d;
    logic              last_d_q, last_d_d;        // 1 = data port granted last
    logic [3:0]        lock_cnt_q, lock_cnt_d;
    logic              rd_pending_q, rd_pending_d;
    logic              rd_owner_q, rd_owner_d;    // 1 = data port owns the read
    logic [CNT_W-1:0]  i_grant_cnt_q, i_grant_cnt_d;
    logic [CNT_W-1:0]  d_grant_cnt_q, d_grant_cnt_d;
    logic [CNT_W-1:0]  i_stall_cnt_q, i_stall_cnt_d;
    logic [CNT_W-1:0]  d_stall_cnt_q, d_stall_cnt_d;

    // ------------------------------------------------------------------
    // Combinational arbitration signals
    // ------------------------------------------------------------------
    logic              i_gnt_w;
    logic              d_gnt_w;
    logic              lock_eff;
    logic              mem_read_w;
    logic              mem_write_w;
    logic [ADDR_W-1:0] addr_w;
    logic              i_rvalid_w;
    logic              d_rvalid_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Lock FSM and arbitration: next state and grants
    // ------------------------------------------------------------------
    always_comb begin
        i_gnt_w      = 1'b0;
        d_gnt_w      = 1'b0;
        lock_state_d = lock_state_q;
        last_d_d     = last_d_q;
        lock_cnt_d   = lock_cnt_q;

        // Once the bound is reached the lock no longer overrides round-robin.
        lock_eff = (lock_state_q == LK_HELD) && (lock_cnt_q < MAX_LOCK_L);

        // Grants are gated by reset_n so nothing is accepted during reset,
        // even with requests asserted.
        if (reset_n) begin
            if (lock_eff && bus.d_req) begin
                d_gnt_w = 1'b1;
            end else if (bus.i_req && bus.d_req) begin
                if (last_d_q) i_gnt_w = 1'b1;
                else          d_gnt_w = 1'b1;
            end else begin
                i_gnt_w = bus.i_req;
                d_gnt_w = bus.d_req;
            end
        end

        if (d_gnt_w) begin
            last_d_d     = 1'b1;
            lock_state_d = bus.d_lock ? LK_HELD : LK_OPEN;
        end else begin
            if (i_gnt_w) last_d_d = 1'b0;
            // Any cycle without a data grant (including d_req dropping)
            // releases the lock.
            lock_state_d = LK_OPEN;
        end

        // Count locked data grants that make the instruction port wait;
        // any other outcome, including an instruction grant, restarts it.
        if (d_gnt_w && bus.d_lock) begin
            if (bus.i_req && (lock_cnt_q < MAX_LOCK_L))
                lock_cnt_d = lock_cnt_q + 4'd1;
        end else begin
            lock_cnt_d = 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // RAM drive
    // ------------------------------------------------------------------
    always_comb begin
        addr_w      = d_gnt_w ? bus.d_addr : bus.i_addr;
        mem_read_w  = i_gnt_w | (d_gnt_w & ~bus.d_we);
        mem_write_w = d_gnt_w & bus.d_we;
    end

    assign bus.i_gnt         = i_gnt_w;
    assign bus.d_gnt         = d_gnt_w;
    assign bus.mem_address   = addr_w;
    assign bus.mem_read      = mem_read_w;
    assign bus.mem_write     = mem_write_w;
    assign bus.mem_writedata = bus.d_wdata;

    // ------------------------------------------------------------------
    // Read response routing and counters: next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_pending_d  = mem_read_w;
        rd_owner_d    = d_gnt_w;
        i_grant_cnt_d = sat_inc(i_grant_cnt_q, i_gnt_w);
        d_grant_cnt_d = sat_inc(d_grant_cnt_q, d_gnt_w);
        i_stall_cnt_d = sat_inc(i_stall_cnt_q, bus.i_req & ~i_gnt_w);
        d_stall_cnt_d = sat_inc(d_stall_cnt_q, bus.d_req & ~d_gnt_w);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_state_q  <= LK_OPEN;
            last_d_q      <= 1'b1;     // instruction wins the first conflict
            lock_cnt_q    <= 4'd0;
            rd_pending_q  <= 1'b0;
            rd_owner_q    <= 1'b0;
            i_grant_cnt_q <= '0;
            d_grant_cnt_q <= '0;
            i_stall_cnt_q <= '0;
            d_stall_cnt_q <= '0;
        end else begin
            lock_state_q  <= lock_state_d;
            last_d_q      <= last_d_d;
            lock_cnt_q    <= lock_cnt_d;
            rd_pending_q  <= rd_pending_d;
            rd_owner_q    <= rd_owner_d;
            i_grant_cnt_q <= i_grant_cnt_d;
            d_grant_cnt_q <= d_grant_cnt_d;
            i_stall_cnt_q <= i_stall_cnt_d;
            d_stall_cnt_q <= d_stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign i_rvalid_w   = rd_pending_q & ~rd_owner_q;
    assign d_rvalid_w   = rd_pending_q &  rd_owner_q;

    assign bus.i_rvalid = i_rvalid_w;
    assign bus.d_rvalid = d_rvalid_w;
    assign bus.i_rdata  = i_rvalid_w ? bus.mem_readdata : {DATA_W{1'b0}};
    assign bus.d_rdata  = d_rvalid_w ? bus.mem_readdata : {DATA_W{1'b0}};

    assign bus.i_grant_cnt = i_grant_cnt_q;
    assign bus.d_grant_cnt = d_grant_cnt_q;
    assign bus.i_stall_cnt = i_stall_cnt_q;
    assign bus.d_stall_cnt = d_stall_cnt_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter_2p
//
// Self-checking bench for ram_arbiter_2p with a behavioural 32x4096 RAM.
// A per-cycle monitor (falling edge) predicts grants, strobes, rvalids and
// counters from a reference model; expected read data is pushed to per-port
// queues when a read is granted and popped when rvalid appears. Directed
// steps follow the listed scenarios, then a short random phase.
// ----------------------------------------------------------------------------
module tb_ram_arbiter_2p;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_LOCK = 4;
    localparam int CNT_W    = 16;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_2p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    ram_arbiter_2p #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // ------------------------------------------------------------------
    // Behavioural RAM (registered read, write visible on the next read)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_rd_q = '0;

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            ram[a]     = 32'h1000_0000 + 32'(a * 7);
            ref_mem[a] = 32'h1000_0000 + 32'(a * 7);
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
        if (bus.mem_read)  ram_rd_q <= ram[bus.mem_address];
    end
    assign bus.mem_readdata = ram_rd_q;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] i_exp_q[$];
    logic [DATA_W-1:0] d_exp_q[$];

    logic             m_last_d = 1'b1;
    logic             m_lock   = 1'b0;
    int               m_lcnt   = 0;
    logic             m_pend_i = 1'b0;
    logic             m_pend_d = 1'b0;
    logic [CNT_W-1:0] m_igc = '0, m_dgc = '0, m_isc = '0, m_dsc = '0;
    logic             gi_seen = 1'b0, gd_seen = 1'b0;
    logic             eg_i, eg_d;

    function automatic logic [CNT_W-1:0] m_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always @(negedge clk) begin
        // responses from reads granted in the previous cycle
        check_val("i_rvalid", bus.i_rvalid, reset_n & m_pend_i);
        check_val("d_rvalid", bus.d_rvalid, reset_n & m_pend_d);
        if (bus.i_rvalid && i_exp_q.size() > 0)
            check_val("i_rdata", bus.i_rdata, i_exp_q.pop_front());
        if (bus.d_rvalid && d_exp_q.size() > 0)
            check_val("d_rdata", bus.d_rdata, d_exp_q.pop_front());

        // expected arbitration for this cycle
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (reset_n) begin
            if (m_lock && m_lcnt < MAX_LOCK && bus.d_req) eg_d = 1'b1;
            else if (bus.i_req && bus.d_req) begin
                if (m_last_d) eg_i = 1'b1;
                else          eg_d = 1'b1;
            end else begin
                eg_i = bus.i_req;
                eg_d = bus.d_req;
            end
        end
        check_val("i_gnt", bus.i_gnt, eg_i);
        check_val("d_gnt", bus.d_gnt, eg_d);
        check_val("mem_read", bus.mem_read, eg_i | (eg_d & ~bus.d_we));
        check_val("mem_write", bus.mem_write, eg_d & bus.d_we);
        if (eg_i) check_val("mem_addr_i", bus.mem_address, bus.i_addr);
        if (eg_d) check_val("mem_addr_d", bus.mem_address, bus.d_addr);
        if (eg_d && bus.d_we) check_val("mem_wdata", bus.mem_writedata, bus.d_wdata);

        // counters reflect grants up to the previous cycle
        check_val("i_grant_cnt", bus.i_grant_cnt, reset_n ? m_igc : 16'd0);
        check_val("d_grant_cnt", bus.d_grant_cnt, reset_n ? m_dgc : 16'd0);
        check_val("i_stall_cnt", bus.i_stall_cnt, reset_n ? m_isc : 16'd0);
        check_val("d_stall_cnt", bus.d_stall_cnt, reset_n ? m_dsc : 16'd0);

        gi_seen = bus.i_gnt;
        gd_seen = bus.d_gnt;

        // model update for the coming rising edge
        if (!reset_n) begin
            m_last_d = 1'b1; m_lock = 1'b0; m_lcnt = 0;
            m_pend_i = 1'b0; m_pend_d = 1'b0;
            m_igc = '0; m_dgc = '0; m_isc = '0; m_dsc = '0;
            i_exp_q.delete();
            d_exp_q.delete();
        end else begin
            if (eg_i) i_exp_q.push_back(ref_mem[bus.i_addr]);
            if (eg_d && !bus.d_we) d_exp_q.push_back(ref_mem[bus.d_addr]);
            if (eg_d && bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
            m_pend_i = eg_i;
            m_pend_d = eg_d & ~bus.d_we;
            m_igc = m_inc(m_igc, eg_i);
            m_dgc = m_inc(m_dgc, eg_d);
            m_isc = m_inc(m_isc, bus.i_req & ~eg_i);
            m_dsc = m_inc(m_dsc, bus.d_req & ~eg_d);
            if (eg_d && bus.d_lock) begin
                if (bus.i_req && m_lcnt < MAX_LOCK) m_lcnt = m_lcnt + 1;
            end else begin
                m_lcnt = 0;
            end
            if (eg_d) m_last_d = 1'b1;
            else if (eg_i) m_last_d = 1'b0;
            m_lock = eg_d & bus.d_lock;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_i(input logic req, input logic [ADDR_W-1:0] addr);
        bus.i_req  = req;
        bus.i_addr = addr;
    endtask

    task automatic drive_d(input logic req, input logic we, input logic lock,
                           input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
        bus.d_req   = req;
        bus.d_we    = we;
        bus.d_lock  = lock;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            next_cycle();
            if (!bus.i_req || gi_seen)
                drive_i($urandom_range(0, 2) != 0, 12'($urandom_range(0, 15)));
            if (!bus.d_req || gd_seen)
                drive_d($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 2) == 0, 12'($urandom_range(0, 15)),
                        $urandom);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [7:0] seq8;
    logic [5:0] seq6;

    initial begin
        // Reset with both requests held
        drive_i(1'b1, 12'h010);
        drive_d(1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
        repeat (2) sample();
        check_val("rst_i_gnt", bus.i_gnt, 1'b0);
        check_val("rst_d_gnt", bus.d_gnt, 1'b0);
        check_val("rst_mem_rd", bus.mem_read, 1'b0);
        check_val("rst_mem_wr", bus.mem_write, 1'b0);
        check_val("rst_rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
        next_cycle();
        reset_n = 1'b1;

        // Continuous reads from both ports: I first, then alternating
        seq8 = '0;
        for (int k = 0; k < 8; k++) begin
            sample();
            if (k == 0) check_val("first_gnt_i", bus.i_gnt, 1'b1);
            seq8 = {seq8[6:0], bus.d_gnt};
        end
        check_val("alt_seq", seq8, 8'b0101_0101);

        // Write then read of 0x005 from the data port
        next_cycle();
        drive_i(1'b0, 12'h010);
        drive_d(1'b1, 1'b1, 1'b0, 12'h005, 32'hDEAD_BEEF);
        sample();
        check_val("wr_strobe", bus.mem_write, 1'b1);
        next_cycle();
        drive_d(1'b1, 1'b0, 1'b0, 12'h005, 32'h0);
        sample();
        check_val("rd_after_wr_strobe", {bus.mem_write, bus.mem_read}, 2'b01);
        next_cycle();
        drive_d(1'b0, 1'b0, 1'b0, 12'h005, 32'h0);
        sample();
        check_val("raw_d_rvalid", bus.d_rvalid, 1'b1);
        check_val("raw_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        check_val("raw_i_rvalid", bus.i_rvalid, 1'b0);

        // Bounded lock: instruction granted last, then locked data stream
        next_cycle();
        drive_i(1'b1, 12'h030);
        sample();
        next_cycle();
        drive_d(1'b1, 1'b0, 1'b1, 12'h040, 32'h0);
        seq6 = '0;
        for (int k = 0; k < 6; k++) begin
            sample();
            seq6 = {seq6[4:0], bus.d_gnt};
        end
        check_val("lock_seq", seq6, 6'b111101);

        // Dropping d_req releases the lock; instruction granted at once
        next_cycle();
        drive_d(1'b0, 1'b0, 1'b0, 12'h040, 32'h0);
        sample();
        check_val("unlock_i_gnt", bus.i_gnt, 1'b1);

        // Reset pulse right after a data read grant
        next_cycle();
        drive_i(1'b0, 12'h030);
        drive_d(1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
        sample();
        check_val("pre_rst_d_gnt", bus.d_gnt, 1'b1);
        next_cycle();
        reset_n = 1'b0;
        drive_d(1'b0, 1'b0, 1'b0, 12'h020, 32'h0);
        sample();
        check_val("rst_kill_rvalid", bus.d_rvalid, 1'b0);
        check_val("rst_d_grant_cnt", bus.d_grant_cnt, 16'd0);
        check_val("rst_i_stall_cnt", bus.i_stall_cnt, 16'd0);
        next_cycle();
        reset_n = 1'b1;
        sample();
        check_val("post_rst_d_rvalid", bus.d_rvalid, 1'b0);

        // Random mix with hold-until-grant requesters
        rand_cycles(400);
        next_cycle();
        drive_i(1'b0, 12'h000);
        drive_d(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        repeat (3) next_cycle();

        // Data port alone long enough to saturate its grant counter
        drive_d(1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
        repeat ((1 << CNT_W) + 5) next_cycle();
        drive_d(1'b0, 1'b0, 1'b0, 12'h020, 32'h0);
        sample();
        check_val("d_grant_sat", bus.d_grant_cnt, 16'hFFFF);
        repeat (2) next_cycle();
        sample();
        check_val("d_grant_hold", bus.d_grant_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
